// File: rtl/pc_redirect_sequencer_if.sv
// pc_redirect_sequencer_if -- instruction-fetch request handshake.
//   fetch_valid  sequencer -> imem  request valid
//   fetch_pc     sequencer -> imem  fetch address (registered)
//   fetch_kill   sequencer -> imem  returned instruction must be dropped
//   fetch_ready  imem -> sequencer  imem accepts the current request
interface pc_redirect_sequencer_if;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        fetch_kill;
  logic        fetch_ready;

  modport master (output fetch_valid, output fetch_pc, output fetch_kill,
                  input  fetch_ready);
  modport slave  (input  fetch_valid, input  fetch_pc, input  fetch_kill,
                  output fetch_ready);
endinterface

// File: rtl/pc_redirect_sequencer.sv
// pc_redirect_sequencer -- owns the fetch PC and sequences branch/JAL/JALR
// redirects against a stallable imem request port.
//   clock, reset       clock; asynchronous active-low reset
//   ex_valid           EX holds a live instruction
//   next_pc_select     00 seq, 01 PC+imm, 10 JALR target, 11 trap
//   ex_pc, ex_imm      PC-relative target operands
//   ex_jalr_sum        rs1 + imm from the ALU
//   trap_req/vector    trap request and handler address (option only)
//   fetch              imem request handshake (master side)
//   flush              registered 1-cycle IF/ID kill pulse per redirect
//   pc_misaligned      redirect target had bit[1] set
// Build option: define TRAP_REDIRECT_EN to enable the trap redirect path;
// without it a misaligned target halts fetch until reset (sticky flag).
module pc_redirect_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           ex_valid,
  input  logic [1:0]                     next_pc_select,
  input  logic [31:0]                    ex_pc,
  input  logic [31:0]                    ex_imm,
  input  logic [31:0]                    ex_jalr_sum,
  input  logic                           trap_req,
  input  logic [31:0]                    trap_vector,
  pc_redirect_sequencer_if.master        fetch,
  output logic                           flush,
  output logic                           pc_misaligned
);

  typedef enum logic [1:0] {BOOT, RUN, PEND, HALT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic        flush_q, flush_d;
  logic        mis_q, mis_d;

  logic        is_branch;
  logic [31:0] br_target;
  logic        mis_event;
  logic        redir;
  logic [31:0] target;
  logic        halt_now;
  logic        unused_bits;

`ifdef TRAP_REDIRECT_EN
  logic        trap_any;
  logic [31:0] trap_target;
  assign unused_bits = ^{ex_jalr_sum[0], trap_vector[1:0]};
`else
  assign unused_bits = ^{ex_jalr_sum[0], trap_req, trap_vector};
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_d    = pend_q;
    flush_d   = 1'b0;
    is_branch = ex_valid & ((next_pc_select == 2'b01) | (next_pc_select == 2'b10));
    br_target = (next_pc_select == 2'b01) ? ex_pc + ex_imm
                                          : {ex_jalr_sum[31:1], 1'b0};
    mis_event = (state_q == RUN) & is_branch & br_target[1];
`ifdef TRAP_REDIRECT_EN
    trap_any    = trap_req | (ex_valid & (next_pc_select == 2'b11));
    trap_target = {trap_vector[31:2], 2'b00};
    // A misaligned branch target is folded into the trap path.
    redir       = trap_any | is_branch;
    target      = (trap_any | br_target[1]) ? trap_target : br_target;
    halt_now    = 1'b0;
    mis_d       = mis_event;
`else
    redir       = is_branch;
    target      = br_target;
    halt_now    = br_target[1];
    mis_d       = mis_q | mis_event;
`endif

    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (redir) begin
          flush_d = 1'b1;
          if (halt_now) begin
            state_d = HALT;
          end else if (fetch.fetch_ready) begin
            pc_d = target;
          end else begin
            // fetch_pc must hold while the request is stalled
            pend_d  = target;
            state_d = PEND;
          end
        end else if (fetch.fetch_ready) begin
          pc_d = pc_q + 32'd4;
        end
      end
      PEND: begin
`ifdef TRAP_REDIRECT_EN
        if (trap_any) pend_d = trap_target;
`endif
        if (fetch.fetch_ready) begin
          pc_d    = pend_d;
          state_d = RUN;
        end
      end
      default: state_d = HALT;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
      flush_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      flush_q <= flush_d;
      mis_q   <= mis_d;
    end
  end

  assign fetch.fetch_valid = (state_q == RUN) | (state_q == PEND);
  assign fetch.fetch_kill  = (state_q == PEND);
  assign fetch.fetch_pc    = pc_q;
  assign flush             = flush_q;
  assign pc_misaligned     = mis_q;

endmodule
